// File: rtl/gray_pkg.sv
// Shared definitions for the gray counter receive path: default widths and
// checker state encoding.
package gray_pkg;

  localparam int unsigned GRAY_WIDTH = 5;
  localparam int unsigned GRAY_ERR_W = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  typedef enum logic [1:0] {
    StIdle   = ST_IDLE,
    StSync   = ST_SYNC,
    StLocked = ST_LOCKED
  } chk_state_e;

endpackage

// File: rtl/gray2bin.sv
// Purely combinational gray-to-binary converter.
module gray2bin #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Each binary bit is the parity of the gray bits at and above it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin_o[i] = ^(gray_i >> i);
  end

endmodule

// File: rtl/gray_decoder_checker.sv
// Decodes an enabled gray counter stream and checks it counts by one,
// tracking lock state and a saturating count of sequence violations.
module gray_decoder_checker
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_WIDTH,
  parameter int unsigned ERR_W = GRAY_ERR_W
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enable,
  input  logic [WIDTH-1:0] entrada_gray,
  output logic [WIDTH-1:0] salida_bin,
  output logic             valid_out,
  output logic             error,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  chk_state_e       state_q;
  logic [WIDTH-1:0] prev_bin_q;
  logic [WIDTH-1:0] salida_bin_q;
  logic             valid_q;
  logic             error_q;
  logic             locked_q;
  logic [ERR_W-1:0] err_count_q;

  logic [WIDTH-1:0] dec_bin;
  logic [WIDTH-1:0] exp_bin;
  logic             seq_ok;
  logic [ERR_W-1:0] err_count_d;

  gray2bin #(
    .WIDTH(WIDTH)
  ) u_gray2bin (
    .gray_i(entrada_gray),
    .bin_o (dec_bin)
  );

  always_comb begin
    exp_bin = prev_bin_q + WIDTH'(1);  // wraps at 2^WIDTH
    seq_ok  = (dec_bin == exp_bin);
    err_count_d = err_count_q;
    if (err_count_q != {ERR_W{1'b1}}) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= StIdle;
      prev_bin_q   <= '0;
      salida_bin_q <= '0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
      locked_q     <= 1'b0;
      err_count_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      if (enable) begin
        // The sample is always taken, even a faulty one, so resync follows it.
        prev_bin_q   <= dec_bin;
        salida_bin_q <= dec_bin;
        valid_q      <= 1'b1;
        unique case (state_q)
          StIdle: begin
            state_q <= StSync;
          end
          StSync: begin
            if (seq_ok) begin
              state_q  <= StLocked;
              locked_q <= 1'b1;
            end
          end
          StLocked: begin
            if (!seq_ok) begin
              state_q     <= StSync;
              locked_q    <= 1'b0;
              error_q     <= 1'b1;
              err_count_q <= err_count_d;
            end
          end
          default: begin
            state_q  <= StIdle;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign salida_bin = salida_bin_q;
  assign valid_out  = valid_q;
  assign error      = error_q;
  assign locked     = locked_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_gray_decoder_checker.sv
// Randomized and directed checks of gray_decoder_checker against a rule-level model.
module tb_gray_decoder_checker;

  localparam int unsigned WIDTH = 5;
  localparam int unsigned ERR_W = 8;
  localparam int MOD     = 1 << WIDTH;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic             clk;
  logic             reset_L;
  logic             enable;
  logic [WIDTH-1:0] entrada_gray;
  logic [WIDTH-1:0] salida_bin;
  logic             valid_out;
  logic             error;
  logic             locked;
  logic [ERR_W-1:0] err_count;

  gray_decoder_checker #(
    .WIDTH(WIDTH),
    .ERR_W(ERR_W)
  ) dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .enable      (enable),
    .entrada_gray(entrada_gray),
    .salida_bin  (salida_bin),
    .valid_out   (valid_out),
    .error       (error),
    .locked      (locked),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  string phase = "init";

  // Reference model: mode 0 = waiting for first sample, 1 = syncing, 2 = locked.
  int m_mode, m_prev, m_bin, m_valid, m_err, m_errc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s/%s: got %0d, expected %0d (t=%0t)", phase, tag, got, want, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] to_gray(input int n);
    int v;
    v = n % MOD;
    return WIDTH'(v ^ (v >> 1));
  endfunction

  // Decode by searching for the count whose gray code matches.
  function automatic int from_gray(input logic [WIDTH-1:0] g);
    for (int n = 0; n < MOD; n++) begin
      if (to_gray(n) == g) return n;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_bin = 0; m_valid = 0; m_err = 0; m_errc = 0;
  endtask

  task automatic check_outputs();
    check("salida_bin", 32'(salida_bin), 32'(m_bin));
    check("valid_out", 32'(valid_out), 32'(m_valid));
    check("error", 32'(error), 32'(m_err));
    check("locked", 32'(locked), 32'(m_mode == 2));
    check("err_count", 32'(err_count), 32'(m_errc));
  endtask

  task automatic step(input logic en, input logic [WIDTH-1:0] g);
    int dec;
    enable       = en;
    entrada_gray = g;
    @(posedge clk);
    m_valid = 0;
    m_err   = 0;
    if (en) begin
      dec = from_gray(g);
      m_valid = 1;
      if (m_mode == 0) begin
        m_mode = 1;
      end else if (dec == (m_prev + 1) % MOD) begin
        m_mode = 2;
      end else if (m_mode == 2) begin
        m_err  = 1;
        m_errc = (m_errc < ERR_MAX) ? m_errc + 1 : ERR_MAX;
        m_mode = 1;
      end
      m_prev = dec;
      m_bin  = dec;
    end
    #1;
    check_outputs();
  endtask

  // Asserts reset between edges and checks outputs clear without a clock edge.
  task automatic async_reset();
    reset_L = 1'b0;
    #2;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    reset_L = 1'b1;
  endtask

  int v;

  initial begin
    reset_L      = 1'b0;
    enable       = 1'b0;
    entrada_gray = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    phase = "reset";
    check_outputs();
    reset_L = 1'b1;

    phase = "first4";
    for (int n = 0; n < 4; n++) step(1'b1, to_gray(n));
    check("locked_after4", 32'(locked), 32'd1);

    phase = "wrap";
    for (int n = 4; n < 44; n++) step(1'b1, to_gray(n));
    check("wrap_errc", 32'(err_count), 32'd0);
    check("wrap_locked", 32'(locked), 32'd1);

    phase = "jump";
    async_reset();
    for (int n = 0; n <= 5; n++) step(1'b1, to_gray(n));
    step(1'b1, 5'b01100);
    check("jump_error", 32'(error), 32'd1);
    check("jump_errc", 32'(err_count), 32'd1);
    check("jump_unlocked", 32'(locked), 32'd0);
    step(1'b1, 5'b01101);
    check("jump_relock", 32'(locked), 32'd1);

    phase = "idle_gap";
    for (int i = 0; i < 10; i++) step(1'b0, WIDTH'($urandom));
    check("gap_held", 32'(salida_bin), 32'd9);
    step(1'b1, to_gray(10));
    check("gap_accept", 32'(locked), 32'd1);

    phase = "repeat";
    step(1'b1, to_gray(11));
    step(1'b1, to_gray(11));
    check("rep_error", 32'(error), 32'd1);
    check("rep_errc", 32'(err_count), 32'd2);

    phase = "random";
    v = 11;
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) v = v + 1;
      else if (r < 8) v = $urandom_range(0, MOD - 1);
      step(r != 9, to_gray(v));
    end

    phase = "mid_reset";
    async_reset();
    step(1'b1, to_gray(20));
    step(1'b1, to_gray(21));
    check("post_reset_lock", 32'(locked), 32'd1);

    phase = "saturate";
    v = 21;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, to_gray(v));
      v = v + 1;
      step(1'b1, to_gray(v));
    end
    check("sat_errc", 32'(err_count), 32'(ERR_MAX));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
